dca_tensor_reduce_ctrl: RTL and testbench

DCA_TENSOR_REDUCE_CTRL -- requirements
Module: dca_tensor_reduce_ctrl

---
 rtl/dca_tensor_reduce_ctrl.sv | 144 ++++++++++++++
 tb/tb_dca_tensor_reduce_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_tensor_reduce_ctrl.sv
// Streaming reduction controller: folds N scalars through an external adder,
// keeping one request in flight and presenting the final accumulator on done.
module dca_tensor_reduce_ctrl #(
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int BW_COUNT         = 16
) (
    input  logic                        clk,
    input  logic                        rstnn,
    input  logic                        enable,
    input  logic                        start,
    input  logic [BW_COUNT-1:0]         cfg_count,
    input  logic                        cfg_is_float,
    input  logic                        cfg_is_sub,
    output logic                        busy,
    input  logic                        s_valid,
    input  logic [BW_TENSOR_SCALAR-1:0] s_data,
    output logic                        s_ready,
    output logic                        add_valid,
    output logic                        add_is_sub,
    output logic                        add_is_float,
    output logic [BW_TENSOR_SCALAR-1:0] add_input0,
    output logic [BW_TENSOR_SCALAR-1:0] add_input1,
    input  logic                        add_result_valid,
    input  logic [BW_TENSOR_SCALAR-1:0] add_result,
    output logic                        done,
    output logic [BW_TENSOR_SCALAR-1:0] result
);

    localparam logic [BW_COUNT-1:0] CNT_ONE = BW_COUNT'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FIRST,
        FETCH,
        WAIT_RESULT,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [BW_TENSOR_SCALAR-1:0] acc;
    logic [BW_TENSOR_SCALAR-1:0] operand;
    logic [BW_TENSOR_SCALAR-1:0] result_reg;
    logic [BW_COUNT-1:0]         remaining;
    logic                        is_float;
    logic                        is_sub;
    logic                        issued;

    // s_ready carries enable so a stalled cycle can never complete a transfer
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cfg_count == '0) ? DONE : LOAD_FIRST;
                end
            end
            LOAD_FIRST: begin
                s_ready = enable;
                if (s_valid) begin
                    state_next = (remaining == CNT_ONE) ? DONE : FETCH;
                end
            end
            FETCH: begin
                s_ready = enable;
                if (s_valid) begin
                    state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (add_result_valid) begin
                    state_next = (remaining == CNT_ONE) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // issued marks every WAIT_RESULT cycle after the first, so the request pulses once
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state      <= IDLE;
            acc        <= '0;
            operand    <= '0;
            result_reg <= '0;
            remaining  <= '0;
            is_float   <= 1'b0;
            is_sub     <= 1'b0;
            issued     <= 1'b0;
        end else if (enable) begin
            state  <= state_next;
            issued <= (state == WAIT_RESULT);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_float  <= cfg_is_float;
                        is_sub    <= cfg_is_sub;
                        remaining <= cfg_count;
                        acc       <= '0;
                    end
                end
                LOAD_FIRST: begin
                    if (s_valid) begin
                        acc       <= s_data;
                        remaining <= remaining - CNT_ONE;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        operand <= s_data;
                    end
                end
                WAIT_RESULT: begin
                    if (add_result_valid) begin
                        acc       <= add_result;
                        remaining <= remaining - CNT_ONE;
                    end
                end
                DONE: begin
                    result_reg <= acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign add_valid    = (state == WAIT_RESULT) && !issued;
    assign add_is_sub   = is_sub;
    assign add_is_float = is_float;
    assign add_input0   = acc;
    assign add_input1   = operand;
    // result already shows the final value during the done cycle itself
    assign result       = (state == DONE) ? acc : result_reg;

endmodule

// File: tb/tb_dca_tensor_reduce_ctrl.sv
// Randomised bench for dca_tensor_reduce_ctrl with a 0- or 3-cycle adder model
// and a fold-based reference for the reduced value and completion cycle.
module tb_dca_tensor_reduce_ctrl;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        enable;
    logic        start;
    logic [15:0] cfg_count;
    logic        cfg_is_float;
    logic        cfg_is_sub;
    logic        busy;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        add_valid;
    logic        add_is_sub;
    logic        add_is_float;
    logic [31:0] add_input0;
    logic [31:0] add_input1;
    logic        add_result_valid;
    logic [31:0] add_result;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    int          done_cycle;
    logic [31:0] last_result;
    logic [31:0] stream_q[$];

    int          lat_sel = 0;
    logic        spur = 1'b0;
    logic [31:0] spur_data = '0;
    logic        p0v = 1'b0, p1v = 1'b0, p2v = 1'b0;
    logic [31:0] p0d = '0, p1d = '0, p2d = '0;

    dca_tensor_reduce_ctrl #(.BW_TENSOR_SCALAR(32), .BW_COUNT(16)) dut (
        .clk(clk), .rstnn(rstnn), .enable(enable), .start(start),
        .cfg_count(cfg_count), .cfg_is_float(cfg_is_float), .cfg_is_sub(cfg_is_sub),
        .busy(busy), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .add_valid(add_valid), .add_is_sub(add_is_sub), .add_is_float(add_is_float),
        .add_input0(add_input0), .add_input1(add_input1),
        .add_result_valid(add_result_valid), .add_result(add_result),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] x);
        real v;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  m;
        int   e;
        logic s;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] addfn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sb, input logic fl);
        if (fl) return r2f(sb ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
        return sb ? a - b : a + b;
    endfunction

    // External adder: combinational when lat_sel is 0, otherwise a 3-stage pipe sharing the stall
    always @(posedge clk) begin
        if (enable) begin
            p0v <= add_valid && (lat_sel != 0);
            p0d <= addfn(add_input0, add_input1, add_is_sub, add_is_float);
            p1v <= p0v;
            p1d <= p0d;
            p2v <= p1v;
            p2d <= p1d;
        end
    end

    assign add_result_valid = (lat_sel == 0) ? add_valid : (p2v | spur);
    assign add_result = (lat_sel == 0) ? addfn(add_input0, add_input1, add_is_sub, add_is_float)
                                       : (spur ? spur_data : p2d);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One reduction over stream_q[0..n-1]; result and timing come from a plain fold and cycle formula
    task automatic applyStimulus(input int n, input bit fl, input bit sb, input int lat,
                                 input int stall_pct, input int gap_pct, input int start_pct,
                                 input bit force_stall, input string tag);
        logic [31:0] exp_res, part, prev_in0, prev_in1;
        int          idx, k, stalls, bubbles, exp_cyc, adds, op_err, hold_err, stall_left;
        bit          seen, prev_en, en_at_done, forced_once;
        logic        prev_av, prev_done, prev_busy;
        lat_sel = lat;
        exp_res = '0;
        if (n > 0) begin
            exp_res = stream_q[0];
            for (int i = 1; i < n; i++) exp_res = addfn(exp_res, stream_q[i], sb, fl);
        end
        exp_cyc = (n == 0) ? 1 : 2 + (n - 1) * (lat + 2);
        @(negedge clk);
        enable = 1'b1; start = 1'b1; cfg_count = 16'(n);
        cfg_is_float = fl; cfg_is_sub = sb; s_valid = 1'b0;
        #1;
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        idx = 0; k = 1; stalls = 0; bubbles = 0; adds = 0; op_err = 0; hold_err = 0;
        stall_left = 0; seen = 0; prev_en = 1; en_at_done = 1; forced_once = 0;
        part = (n > 0) ? stream_q[0] : '0;
        prev_av = 0; prev_done = 0; prev_busy = 0; prev_in0 = '0; prev_in1 = '0;
        for (int cyc = 1; cyc <= 2000 && !seen; cyc++) begin
            @(negedge clk);
            start        = ($urandom_range(99) < start_pct);
            cfg_count    = 16'($urandom);
            cfg_is_float = 1'($urandom);
            cfg_is_sub   = 1'($urandom);
            if (stall_left > 0) begin
                enable = 1'b0;
                stall_left--;
            end else begin
                enable = !($urandom_range(99) < stall_pct);
            end
            s_valid = (idx < n) && !($urandom_range(99) < gap_pct);
            s_data  = s_valid ? stream_q[idx] : $urandom;
            #1;
            if (!prev_en && (add_valid !== prev_av || done !== prev_done || busy !== prev_busy ||
                             add_input0 !== prev_in0 || add_input1 !== prev_in1)) hold_err++;
            if (!enable && s_ready) hold_err++;
            if (done) begin
                seen = 1; done_cycle = cyc; last_result = result; en_at_done = enable;
            end else begin
                if (!enable) stalls++;
                if (s_ready && !s_valid) bubbles++;
                if (s_ready && s_valid) idx++;
                if (add_valid && enable) begin
                    if (k >= n || add_input0 !== part || add_input1 !== stream_q[k] ||
                        add_is_sub !== sb || add_is_float !== fl) op_err++;
                    if (k < n) part = addfn(part, stream_q[k], sb, fl);
                    k++;
                    adds++;
                    if (force_stall && !forced_once) begin
                        stall_left = 3; forced_once = 1;
                    end
                end
            end
            prev_en = enable; prev_av = add_valid; prev_done = done; prev_busy = busy;
            prev_in0 = add_input0; prev_in1 = add_input1;
            @(posedge clk);
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            @(negedge clk); rstnn = 1'b0; @(posedge clk);
            @(negedge clk); rstnn = 1'b1;
            return;
        end
        checkOutput({tag, "_cycle"}, done_cycle, exp_cyc + stalls + bubbles);
        checkOutput({tag, "_result"}, last_result, exp_res);
        checkOutput({tag, "_adds"}, adds, (n > 0) ? n - 1 : 0);
        checkOutput({tag, "_operands"}, op_err, 0);
        checkOutput({tag, "_stallhold"}, hold_err, 0);
        if (force_stall) checkOutput({tag, "_forced"}, {31'd0, forced_once}, 32'd1);
        @(negedge clk);
        enable = 1'b1; start = 1'b0; s_valid = 1'b0;
        #1;
        if (!en_at_done) begin
            checkOutput({tag, "_donehold"}, {31'd0, done}, 32'd1);
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_doneclr"}, {30'd0, done, busy}, 32'd0);
        checkOutput({tag, "_held"}, result, exp_res);
    endtask

    // Abandon a reduction while the 3-cycle adder holds a request, then inject a stray response
    task automatic resetMidFlight();
        int idx, bad;
        bit got;
        stream_q = '{32'd1, 32'd2, 32'd3};
        lat_sel = 3; idx = 0; got = 0; bad = 0;
        @(negedge clk);
        enable = 1'b1; start = 1'b1; cfg_count = 16'd3; cfg_is_float = 0; cfg_is_sub = 0;
        @(posedge clk);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            s_valid = (idx < 3);
            s_data = (idx < 3) ? stream_q[idx] : 32'd0;
            #1;
            if (add_valid) got = 1;
            else if (s_ready && s_valid) idx++;
            @(posedge clk);
        end
        checkOutput("rst_reach_wait", {31'd0, got}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0; rstnn = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstnn = 1'b1; enable = 1'b1;
        #1;
        checkOutput("rst_ctrl", {28'd0, busy, done, s_ready, add_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_acc", add_input0, 32'd0);
        checkOutput("rst_operand", add_input1, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            spur = (c == 1);
            spur_data = $urandom | 32'h1;
            #1;
            if (busy || done || add_valid || s_ready || add_input0 !== 32'd0) bad++;
            @(posedge clk);
        end
        @(negedge clk);
        spur = 1'b0;
        checkOutput("rst_spurious", bad, 0);
        stream_q = '{32'd5, 32'd6};
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, "rst_fresh");
        checkOutput("rst_fresh_val", last_result, 32'd11);
    endtask

    initial begin
        int n;
        bit fl;
        rstnn = 1'b0; enable = 1'b1; start = 1'b0; cfg_count = '0;
        cfg_is_float = 1'b0; cfg_is_sub = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        #1;
        checkOutput("reset_ctrl", {28'd0, busy, done, s_ready, add_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);

        stream_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        applyStimulus(4, 0, 0, 0, 0, 0, 0, 0, "sum4");
        checkOutput("sum4_val", last_result, 32'd10);
        checkOutput("sum4_at", done_cycle, 8);

        stream_q = '{32'd10, 32'd3, 32'd2};
        applyStimulus(3, 0, 1, 0, 0, 0, 0, 0, "sub3");
        checkOutput("sub3_val", last_result, 32'd5);

        stream_q = '{32'h7FFF_FFFF, 32'd1};
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, "wrap");
        checkOutput("wrap_val", last_result, 32'h8000_0000);

        stream_q = '{32'h3F80_0000, 32'h4000_0000};
        applyStimulus(2, 1, 0, 3, 0, 0, 0, 0, "fadd");
        checkOutput("fadd_val", last_result, 32'h4040_0000);
        checkOutput("fadd_at", done_cycle, 7);

        stream_q = '{};
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "n0");
        checkOutput("n0_val", last_result, 32'd0);
        checkOutput("n0_at", done_cycle, 1);

        stream_q = '{32'h1234_5678};
        applyStimulus(1, 0, 0, 3, 0, 0, 0, 0, "n1");
        checkOutput("n1_val", last_result, 32'h1234_5678);
        checkOutput("n1_at", done_cycle, 2);

        stream_q = '{32'd7, 32'd8, 32'd9};
        applyStimulus(3, 0, 0, 0, 0, 0, 100, 0, "busystart");
        checkOutput("busystart_val", last_result, 32'd24);

        stream_q = '{32'd100, 32'd20, 32'd3, 32'd4};
        applyStimulus(4, 0, 1, 3, 10, 30, 0, 1, "stall");
        checkOutput("stall_val", last_result, 32'd73);

        resetMidFlight();

        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(0, 8);
            fl = 1'($urandom);
            stream_q = '{};
            for (int i = 0; i < n; i++) begin
                if (fl) stream_q.push_back(r2f(real'(int'($urandom_range(0, 1000)) - 500)));
                else stream_q.push_back($urandom);
            end
            applyStimulus(n, fl, 1'($urandom), 3 * int'($urandom_range(0, 1)), 15, 25, 10, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
